// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, next-PC selection, trap redirection and the IF/ID
// pipeline register. The optional interrupt path is enabled by defining INSTR_FETCH_IRQ_EN;
// without it irq is ignored and epc only updates on exceptions.
module instr_fetch (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        stall,
  input  logic        flush,
  input  logic [1:0]  pc_src,
  input  logic [31:0] branch_target,
  input  logic [25:0] jump_idx,
  input  logic [31:0] jr_target,
  input  logic        irq,
  input  logic        exc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [31:0] epc
);

  localparam logic [31:0] ResetPc = 32'h8000_0000;
  localparam logic [31:0] IrqPc   = 32'h8000_0004;
  localparam logic [31:0] ExcPc   = 32'h8000_0008;

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] epc_q, epc_d;

  logic [31:0] pc_plus4;
  logic [31:0] jump_target;
  logic [31:0] pc_sel;
  logic        irq_take;
  logic        trap;

  // Bit 31 is the supervisor flag; only the low 31 bits increment and wrap.
  assign pc_plus4    = {pc_q[31], pc_q[30:0] + 31'd4};
  assign jump_target = {pc_plus4[31:28], jump_idx, 2'b00};

`ifdef INSTR_FETCH_IRQ_EN
  // Interrupts are masked while running in supervisor space.
  assign irq_take = irq & ~pc_q[31];
`else
  logic unused_irq;
  assign unused_irq = irq;
  assign irq_take   = 1'b0;
`endif

  assign trap = exc | irq_take;

  // Select the non-trap next PC from pc_src.
  always_comb begin
    pc_sel = pc_plus4;
    unique case (pc_src)
      2'd0: pc_sel = pc_plus4;
      2'd1: pc_sel = branch_target;
      2'd2: pc_sel = jump_target;
      2'd3: pc_sel = jr_target;
      default: pc_sel = pc_plus4;
    endcase
  end

  // Next PC, IF/ID contents and epc; flush wins over stall for IF/ID only.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    epc_d   = epc_q;

    if (exc) begin
      pc_d = ExcPc;
    end else if (irq_take) begin
      pc_d = IrqPc;
    end else if (!stall) begin
      pc_d = pc_sel;
    end

    if (trap) begin
      epc_d   = pc_q;
      instr_d = '0;
      pc4_d   = '0;
      valid_d = 1'b0;
    end else if (flush) begin
      instr_d = '0;
      pc4_d   = '0;
      valid_d = 1'b0;
    end else if (!stall) begin
      instr_d = rom_data;
      pc4_d   = pc_plus4;
      valid_d = 1'b1;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= ResetPc;
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      epc_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      epc_q   <= epc_d;
    end
  end

  assign rom_addr    = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_valid = valid_q;
  assign epc         = epc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios followed by random stimulus, all
// checked against a behavioural model of the fetch rules.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        stall;
  logic        flush;
  logic [1:0]  pc_src;
  logic [31:0] branch_target;
  logic [25:0] jump_idx;
  logic [31:0] jr_target;
  logic        irq;
  logic        exc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic [31:0] epc;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef INSTR_FETCH_IRQ_EN
  localparam bit IrqEn = 1'b1;
`else
  localparam bit IrqEn = 1'b0;
`endif

  // Model state
  logic [31:0] m_pc, m_instr, m_pc4, m_epc;
  logic        m_valid;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk          (clk),
    .reset        (reset),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .stall        (stall),
    .flush        (flush),
    .pc_src       (pc_src),
    .branch_target(branch_target),
    .jump_idx     (jump_idx),
    .jr_target    (jr_target),
    .irq          (irq),
    .exc          (exc),
    .if_id_instr  (if_id_instr),
    .if_id_pc4    (if_id_pc4),
    .if_id_valid  (if_id_valid),
    .epc          (epc)
  );

  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  assign rom_data = rom_fn(rom_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".rom_addr"}, rom_addr, m_pc);
    check({tag, ".instr"}, if_id_instr, m_instr);
    check({tag, ".pc4"}, if_id_pc4, m_pc4);
    check({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, m_valid});
    check({tag, ".epc"}, epc, m_epc);
  endtask

  task automatic model_reset();
    m_pc = 32'h8000_0000; m_instr = 0; m_pc4 = 0; m_valid = 0; m_epc = 0;
  endtask

  // One rising edge of the fetch rules, in priority order.
  task automatic model_edge();
    logic [31:0] inc, nxt;
    bit          irq_hit;
    inc     = (m_pc & 32'h8000_0000) | ((m_pc + 32'd4) & 32'h7FFF_FFFF);
    irq_hit = IrqEn && irq && (m_pc < 32'h8000_0000);
    case (pc_src)
      2'd0:    nxt = inc;
      2'd1:    nxt = branch_target;
      2'd2:    nxt = (inc & 32'hF000_0000) | (32'(jump_idx) * 4);
      default: nxt = jr_target;
    endcase
    if (exc || irq_hit) begin
      m_epc = m_pc; m_instr = 0; m_pc4 = 0; m_valid = 0;
      m_pc  = exc ? 32'h8000_0008 : 32'h8000_0004;
    end else begin
      if (flush) begin
        m_instr = 0; m_pc4 = 0; m_valid = 0;
      end else if (!stall) begin
        m_instr = rom_fn(m_pc); m_pc4 = inc; m_valid = 1;
      end
      if (!stall) m_pc = nxt;
    end
  endtask

  task automatic step(input logic s, input logic f, input logic [1:0] src, input logic [31:0] bt,
                      input logic [25:0] ji, input logic [31:0] jt, input logic i, input logic e,
                      input string tag);
    stall = s; flush = f; pc_src = src; branch_target = bt; jump_idx = ji; jr_target = jt;
    irq = i; exc = e;
    model_edge();
    @(posedge clk); #1;
    check_all(tag);
  endtask

  initial begin
    reset = 1'b0; stall = 0; flush = 0; pc_src = 0; branch_target = 0; jump_idx = 0;
    jr_target = 0; irq = 0; exc = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    check("reset.pc_const", rom_addr, 32'h8000_0000);
    reset = 1'b1;

    // Sequential fetch after release
    step(0, 0, 0, 0, 0, 0, 0, 0, "seq1");
    check("seq1.pc_const", rom_addr, 32'h8000_0004);
    check("seq1.instr_const", if_id_instr, rom_fn(32'h8000_0000));
    step(0, 0, 0, 0, 0, 0, 0, 0, "seq2");
    step(0, 0, 0, 0, 0, 0, 0, 0, "seq3");
    check("seq3.pc_const", rom_addr, 32'h8000_000C);
    check("seq3.pc4_const", if_id_pc4, 32'h8000_000C);

    // Jump and branch
    step(0, 0, 3, 0, 0, 32'h10, 0, 0, "jr10");
    step(0, 0, 2, 32'hFFFF_FFFF, 26'h2D, 0, 0, 0, "jump");
    check("jump.pc_const", rom_addr, 32'h0000_00B4);
    step(0, 0, 1, 32'h78, 26'h3FF_FFFF, 32'hDEAD_BEEF, 0, 0, "branch");
    check("branch.pc_const", rom_addr, 32'h0000_0078);

    // Stall with flush holds PC and inserts a bubble
    step(0, 0, 3, 0, 0, 32'h20, 0, 0, "jr20");
    step(1, 1, 1, 32'h1234, 0, 0, 0, 0, "stallflush");
    check("stallflush.pc_const", rom_addr, 32'h20);
    step(0, 0, 0, 0, 0, 0, 0, 0, "after_sf");
    check("after_sf.instr_const", if_id_instr, rom_fn(32'h20));

    // Interrupt, then masked interrupt in supervisor space
    step(0, 0, 3, 0, 0, 32'h40, 0, 0, "jr40");
    step(0, 0, 0, 0, 0, 0, 1, 0, "irq");
    step(0, 0, 3, 0, 0, 32'h8000_0010, 1, 0, "jr_sup");
    step(0, 0, 0, 0, 0, 0, 1, 0, "irq_masked");
    check("irq_masked.pc_const", rom_addr, IrqEn ? 32'h8000_0014 : 32'h8000_0014);

    // Exception beats interrupt
    step(0, 0, 3, 0, 0, 32'h40, 0, 0, "jr40b");
    step(0, 0, 2, 0, 0, 0, 1, 1, "exc_irq");
    check("exc_irq.pc_const", rom_addr, 32'h8000_0008);
    check("exc_irq.epc_const", epc, 32'h40);

    // Random stimulus
    for (int k = 0; k < 300; k++) begin
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0), 2'($urandom_range(0, 3)),
           $urandom & 32'hFFFF_FFFC, 26'($urandom), $urandom & 32'hFFFF_FFFC,
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 15) == 0), "rand");
    end

    // Reset during a stall acts without a clock edge
    step(1, 0, 3, 0, 0, 32'h44, 0, 0, "pre_rst");
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk); #1;
    reset = 1'b1;
    stall = 0;
    step(0, 0, 0, 0, 0, 0, 0, 0, "post_rst");
    check("post_rst.instr_const", if_id_instr, rom_fn(32'h8000_0000));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have these ports (name, direction, width, meaning), clock and reset first:
- clk, in, 1: single clock; all state updates on the rising edge.
- reset, in, 1: asynchronous, active-low.
- rom_addr, out, 32: current PC, driven combinationally to the instruction ROM.
- rom_data, in, 32: ROM word at rom_addr, valid in the same cycle.
- stall, in, 1: hold PC and IF/ID register.
- flush, in, 1: replace the IF/ID contents with a bubble.
- pc_src, in, 2: next-PC select. 0 = PC+4, 1 = branch, 2 = jump, 3 = jr.
- branch_target, in, 32: branch destination.
- jump_idx, in, 26: J-type index field.
- jr_target, in, 32: register-jump destination.
- irq, in, 1: level-sensitive interrupt request.
- exc, in, 1: undefined-instruction exception pulse.
- if_id_instr, out, 32: latched instruction.
- if_id_pc4, out, 32: latched PC+4.
- if_id_valid, out, 1: latched instruction is real (1) or a bubble (0).
- epc, out, 32: return address captured on a trap.

Function
REQ-002 rom_addr SHALL equal the PC register at all times; there is no combinational path from any input to rom_addr.
REQ-003 pc_plus4 SHALL be {PC[31], PC[30:0]+4}; bit 31 (supervisor) is preserved and bits [30:0] wrap modulo 2^31.
REQ-004 The jump target SHALL be {pc_plus4[31:28], jump_idx, 2'b00}; branch_target and jr_target SHALL be used unmodified.
REQ-005 Per-edge priority SHALL be: exc, then irq, then stall, then normal.
- exc: PC <= 0x80000008.
- irq: taken only when IRQ_EN is defined and PC[31]=0; PC <= 0x80000004.
- stall: PC and the IF/ID register are held.
- normal: PC <= the pc_src selection.
REQ-006 On any trap (exc or taken irq), epc SHALL be set to the current PC, and the IF/ID register SHALL load a bubble: if_id_instr=0, if_id_valid=0, if_id_pc4=0. On any other edge, epc SHALL hold.
REQ-007 On a normal edge with flush=0, the IF/ID register SHALL load if_id_instr <= rom_data, if_id_pc4 <= pc_plus4, if_id_valid <= 1.
REQ-008 flush=1 SHALL override stall for the IF/ID register (a bubble is loaded), while PC still obeys REQ-005. Simultaneous stall=1 and flush=1 SHALL therefore hold PC and insert a bubble.
REQ-009 Fetch latency SHALL be one cycle: the instruction at PC appears on if_id_instr after the next rising edge.
REQ-010 irq SHALL be ignored while PC[31]=1, and exc SHALL be honoured regardless of PC[31].
REQ-011 pc_src SHALL be ignored on trap and stall edges.

Reset
REQ-012 While reset=0:
- PC = 0x80000000.
- if_id_instr = 0, if_id_pc4 = 0, if_id_valid = 0.
- epc = 0.
REQ-013 Reset asserted mid-operation SHALL take effect immediately, without waiting for clk. On the first edge after release, the block SHALL perform a normal fetch from 0x80000000.

Configuration
REQ-014 The interrupt path SHALL be controlled by the macro INSTR_FETCH_IRQ_EN.
- Defined: irq is honoured per REQ-005 and REQ-010.
- Undefined: irq is ignored entirely, and epc updates only on exc.

Verification
REQ-015 Reset, release, pc_src=0 for 3 cycles -> rom_addr goes 0x80000000, 0x80000004, 0x80000008, 0x8000000C; if_id_pc4 follows one cycle later; if_id_valid=1 from the first edge.
REQ-016 PC=0x00000010, pc_src=2, jump_idx=0x000002D -> next PC=0x000000B4. pc_src=1, branch_target=0x00000078 -> next PC=0x00000078.
REQ-017 PC=0x00000020, stall=1 and flush=1 for 1 cycle -> PC stays 0x00000020 and if_id_valid=0. The following cycle, if_id_instr=rom_data(0x20).
REQ-018 With INSTR_FETCH_IRQ_EN defined: PC=0x00000040, irq=1 -> PC=0x80000004, epc=0x00000040, bubble loaded. Then PC=0x80000010 with irq held at 1 -> no trap, PC=0x80000014. Without the macro, irq=1 has no effect.
REQ-019 exc=1 and irq=1 together at PC=0x00000040 -> PC=0x80000008 and epc=0x00000040. Asserting reset mid-stall -> PC=0x80000000 immediately.
